// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - shared types, constants and helpers for the sound-effect scheduler
package sfx_pkg;

  localparam int NUM_SFX = 4;
  localparam int ROM_AW  = 5;
  localparam int IDX_W   = 5;
  localparam int ROM_DW  = 14;

  // Note ROM entry layout: {last, idx[4:0], dur[7:0]}
  localparam int LAST_BIT = 13;
  localparam int IDX_MSB  = 12;
  localparam int IDX_LSB  = 8;
  localparam int DUR_MSB  = 7;

  localparam logic [IDX_W-1:0] REST_IDX = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2
  } state_t;

  // Each effect owns an 8-entry slice of the note ROM: 0, 8, 16, 24
  function automatic logic [ROM_AW-1:0] start_addr(input logic [1:0] s);
    return {s, 3'b000};
  endfunction

  // Highest set bit wins; caller guarantees v != 0
  function automatic logic [1:0] top_bit(input logic [NUM_SFX-1:0] v);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < NUM_SFX; i++) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/sfx_note_rom.sv
// rtl/sfx_note_rom.sv - note ROM with registered (1-cycle latency) read port
module sfx_note_rom
  import sfx_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ROM_AW-1:0] addr,
  output logic [ROM_DW-1:0] q
);

  // Note table contents (the sfx_notes.mem image) as a constant lookup
  function automatic logic [ROM_DW-1:0] rom_word(input logic [ROM_AW-1:0] a);
    logic [ROM_DW-1:0] w;
    case (a)
      // flap
      5'd0:    w = {1'b0, 5'd4,  8'd2};
      5'd1:    w = {1'b1, 5'd7,  8'd1};
      // score: rest then a zero-duration note (plays one tick)
      5'd8:    w = {1'b0, 5'd31, 8'd3};
      5'd9:    w = {1'b1, 5'd9,  8'd0};
      // hit
      5'd16:   w = {1'b0, 5'd10, 8'd1};
      5'd17:   w = {1'b1, 5'd12, 8'd1};
      // game-over
      5'd24:   w = {1'b1, 5'd20, 8'd2};
      default: w = {1'b1, 5'd31, 8'd1};
    endcase
    return w;
  endfunction

  // Synchronous read; output clears on reset so tone_idx starts at 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= rom_word(addr);
  end

endmodule

// File: rtl/sfx_scheduler.sv
// rtl/sfx_scheduler.sv - sound-effect request latch, priority launch and note sequencer (optional SFX_PREEMPT_EN)
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int SYS_FREQ = 100000000,
  parameter int TICK_HZ  = 100
)(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SFX-1:0] req,
  output logic [IDX_W-1:0]   tone_idx,
  output logic               tone_en,
  output logic               busy,
  output logic [1:0]         cur_sfx,
  output logic               sfx_done
);

  localparam logic [31:0] TICK_MAX = 32'(SYS_FREQ / TICK_HZ - 1);

  state_t              state, state_n;
  logic [ROM_AW-1:0]   addr, addr_n;
  logic [NUM_SFX-1:0]  pending, pending_n, clr;
  logic [1:0]          cur_n, sel;
  logic                sounding, sounding_n, done_n;
  logic [31:0]         tick_cnt, tick_n;
  logic [7:0]          elapsed, elapsed_n;
  logic [ROM_DW-1:0]   rom_q;
  logic [7:0]          note_dur;
  logic [IDX_W-1:0]    note_idx;
  logic                note_last;

  sfx_note_rom u_rom (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .q     (rom_q)
  );

  assign note_idx  = rom_q[IDX_MSB:IDX_LSB];
  assign note_last = rom_q[LAST_BIT];
  assign note_dur  = (rom_q[DUR_MSB:0] == 8'd0) ? 8'd1 : rom_q[DUR_MSB:0];

  // rom_q only changes when leaving FETCH, so the previous note holds through the gap
  assign tone_idx = note_idx;
  assign tone_en  = sounding && (note_idx != REST_IDX);
  assign busy     = (state != IDLE);
  assign sel      = top_bit(pending);

  // Next-state, note sequencing, request latch and launch/preempt decisions
  always_comb begin
    state_n    = state;
    addr_n     = addr;
    cur_n      = cur_sfx;
    clr        = '0;
    sounding_n = sounding;
    done_n     = 1'b0;
    tick_n     = tick_cnt;
    elapsed_n  = elapsed;

    case (state)
      IDLE: begin
        if (pending != '0) begin
          state_n = FETCH;
          addr_n  = start_addr(sel);
          cur_n   = sel;
          clr     = NUM_SFX'(1) << sel;
        end
      end
      FETCH: begin
        state_n    = PLAY;
        sounding_n = 1'b1;
        tick_n     = '0;
        elapsed_n  = '0;
      end
      PLAY: begin
        if (tick_cnt == TICK_MAX) begin
          tick_n = '0;
          if ({1'b0, elapsed} + 9'd1 >= {1'b0, note_dur}) begin
            if (note_last) begin
              state_n    = IDLE;
              done_n     = 1'b1;
              sounding_n = 1'b0;
            end else begin
              state_n = FETCH;
              addr_n  = addr + 1'b1;
            end
          end else begin
            elapsed_n = elapsed + 8'd1;
          end
        end else begin
          tick_n = tick_cnt + 32'd1;
        end
      end
      default: state_n = IDLE;
    endcase

`ifdef SFX_PREEMPT_EN
    // A strictly higher pending effect drops the current one without sfx_done
    if (state != IDLE && pending != '0 && sel > cur_sfx) begin
      state_n    = FETCH;
      addr_n     = start_addr(sel);
      cur_n      = sel;
      clr        = NUM_SFX'(1) << sel;
      sounding_n = 1'b0;
      done_n     = 1'b0;
    end
`endif

    // A request coinciding with its own launch survives the clear and replays
    pending_n = (pending & ~clr) | req;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      pending  <= '0;
      cur_sfx  <= '0;
      sounding <= 1'b0;
      sfx_done <= 1'b0;
      tick_cnt <= '0;
      elapsed  <= '0;
    end else begin
      state    <= state_n;
      addr     <= addr_n;
      pending  <= pending_n;
      cur_sfx  <= cur_n;
      sounding <= sounding_n;
      sfx_done <= done_n;
      tick_cnt <= tick_n;
      elapsed  <= elapsed_n;
    end
  end

endmodule
